// File: rtl/mem_port_arbiter_if.sv
// Processor-side and memory-side signals of the shared memory port.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 16
);
    logic                 DReadReq;
    logic                 DWriteReq;
    logic [ADDR_BITS-1:0] DAddr;
    logic [WORD_SIZE-1:0] DWData;
    logic [WORD_SIZE-1:0] DRData;
    logic                 DataDone;
    logic                 IReq;
    logic [ADDR_BITS-1:0] IAddr;
    logic [WORD_SIZE-1:0] IData;
    logic                 IValid;
    logic [ADDR_BITS-1:0] MemAddr;
    logic [WORD_SIZE-1:0] MemWData;
    logic                 MemRead;
    logic                 MemWrite;
    logic [WORD_SIZE-1:0] MemRData;

    modport slave (
        input  DReadReq, DWriteReq, DAddr, DWData, IReq, IAddr, MemRData,
        output DRData, DataDone, IData, IValid, MemAddr, MemWData, MemRead, MemWrite
    );

    modport master (
        output DReadReq, DWriteReq, DAddr, DWData, IReq, IAddr, MemRData,
        input  DRData, DataDone, IData, IValid, MemAddr, MemWData, MemRead, MemWrite
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and data
// accesses; data is favoured, but a starvation counter forces a fetch through.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_BITS    = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [2:0] LAT_LAST   = 3'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_D,
        OWN_I
    } owner_t;

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    logic [2:0]           lat_cnt_q, lat_cnt_d;
    logic [3:0]           starve_cnt_q, starve_cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 dread_q, dread_d;
    logic [WORD_SIZE-1:0] drdata_q, drdata_d;

    logic data_req;
    logic starved;
    logic complete;
    logic grant_d;
    logic grant_i;

    assign data_req = bus.DReadReq | bus.DWriteReq;
    assign starved  = bus.IReq && (starve_cnt_q == STARVE_MAX);
    assign complete = (state_q == ST_WAIT) && (lat_cnt_q == LAT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dread_q      <= 1'b0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dread_q      <= dread_d;
            drdata_q     <= drdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dread_d      = dread_q;
        drdata_d     = drdata_q;
        grant_d      = 1'b0;
        grant_i      = 1'b0;

        bus.MemAddr  = addr_q;
        bus.MemWData = wdata_q;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IData    = '0;
        bus.IValid   = 1'b0;
        bus.DataDone = 1'b1;

        case (state_q)
            ST_IDLE: begin
                bus.DataDone = !data_req;
                // No grant may be issued while reset is held, since the strobes must stay low.
                if (!Reset) begin
                    if (data_req && !starved) begin
                        grant_d = 1'b1;
                    end else if (bus.IReq) begin
                        grant_i = 1'b1;
                    end
                end

                if (grant_d) begin
                    bus.MemAddr  = bus.DAddr;
                    bus.MemWData = bus.DWData;
                    bus.MemWrite = bus.DWriteReq;
                    bus.MemRead  = bus.DReadReq & ~bus.DWriteReq;
                    addr_d       = bus.DAddr;
                    wdata_d      = bus.DWData;
                    dread_d      = bus.DReadReq & ~bus.DWriteReq;
                    owner_d      = OWN_D;
                    lat_cnt_d    = 3'd1;
                    state_d      = ST_WAIT;
                    if (!bus.IReq) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (grant_i) begin
                    bus.MemAddr  = bus.IAddr;
                    bus.MemRead  = 1'b1;
                    addr_d       = bus.IAddr;
                    owner_d      = OWN_I;
                    lat_cnt_d    = 3'd1;
                    state_d      = ST_WAIT;
                    starve_cnt_d = '0;
                end
            end

            ST_WAIT: begin
                if (complete) begin
                    state_d   = ST_IDLE;
                    owner_d   = OWN_NONE;
                    lat_cnt_d = '0;
                    if (owner_q == OWN_D) begin
                        bus.DataDone = 1'b1;
                        if (dread_q) begin
                            drdata_d = bus.MemRData;
                        end
                    end else begin
                        bus.IData    = bus.MemRData;
                        bus.IValid   = 1'b1;
                        bus.DataDone = !data_req;
                    end
                end else begin
                    lat_cnt_d    = lat_cnt_q + 3'd1;
                    bus.DataDone = (owner_q == OWN_D) ? 1'b0 : !data_req;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (Reset) begin
            bus.DataDone = 1'b1;
        end
    end

    assign bus.DRData = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-driven check of the memory port arbiter at latency 1, plus hand-written
// latency-3 sequences on a second instance.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    int n_checks;
    int n_err;

    mem_port_arbiter_if #(.WORD_SIZE(16), .ADDR_BITS(16)) bus1();
    mem_port_arbiter_if #(.WORD_SIZE(16), .ADDR_BITS(16)) bus3();

    mem_port_arbiter #(.WORD_SIZE(16), .ADDR_BITS(16), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus1)
    );

    mem_port_arbiter #(.WORD_SIZE(16), .ADDR_BITS(16), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: writes commit at the sampling edge, read data follows the sampled address.
    logic [15:0] mem1 [4096];
    logic [15:0] mem3 [4096];
    logic [11:0] rd1_q;
    logic [11:0] rd3_q;

    always @(posedge clk) begin
        if (rst) begin
            mem1[12'h010] <= 16'h5A03;
            mem1[12'h100] <= 16'hBEEF;
            mem3[12'h010] <= 16'h5A03;
            mem3[12'h100] <= 16'hBEEF;
        end
        if (bus1.MemWrite) mem1[bus1.MemAddr[11:0]] <= bus1.MemWData;
        if (bus1.MemRead)  rd1_q <= bus1.MemAddr[11:0];
        if (bus3.MemWrite) mem3[bus3.MemAddr[11:0]] <= bus3.MemWData;
        if (bus3.MemRead)  rd3_q <= bus3.MemAddr[11:0];
    end

    assign bus1.MemRData = mem1[rd1_q];
    assign bus3.MemRData = mem3[rd3_q];

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        drd;
        logic        dwr;
        logic [15:0] daddr;
        logic [15:0] dwd;
        logic        mrd;
        logic        mwr;
        logic [15:0] maddr;
        logic        done;
        logic        ival;
        logic [15:0] idata;
        logic [15:0] drdata;
    } vec_t;

    localparam int NVEC = 35;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [15:0] ia,
        input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
        input logic mr, input logic mw, input logic [15:0] ma,
        input logic dn, input logic iv, input logic [15:0] id, input logic [15:0] drd);
        vec_t v;
        v.rst = r; v.ireq = ir; v.iaddr = ia;
        v.drd = dr; v.dwr = dw; v.daddr = da; v.dwd = dd;
        v.mrd = mr; v.mwr = mw; v.maddr = ma;
        v.done = dn; v.ival = iv; v.idata = id; v.drdata = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;
        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        bus1.DReadReq = 0; bus1.DWriteReq = 0; bus1.DAddr = 0; bus1.DWData = 0;
        bus1.IReq = 0; bus1.IAddr = 0;
        bus3.DReadReq = 0; bus3.DWriteReq = 0; bus3.DAddr = 0; bus3.DWData = 0;
        bus3.IReq = 0; bus3.IAddr = 0;

        //              rst ireq iaddr    drd dwr daddr    dwd       mrd mwr maddr    done ival idata     drdata
        vecs[0]  = mk(1, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);
        vecs[1]  = mk(1, 1, 16'h10,  0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);
        vecs[2]  = mk(0, 1, 16'h10,  0, 0, 16'h0,   16'h0,    1, 0, 16'h10,  1, 0, 16'h0,    16'h0);
        vecs[3]  = mk(0, 0, 16'h10,  0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 1, 16'h5A03, 16'h0);
        vecs[4]  = mk(0, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);
        vecs[5]  = mk(0, 0, 16'h0,   1, 0, 16'h100, 16'h0,    1, 0, 16'h100, 0, 0, 16'h0,    16'h0);
        vecs[6]  = mk(0, 0, 16'h0,   1, 0, 16'h100, 16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);
        vecs[7]  = mk(0, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'hBEEF);
        vecs[8]  = mk(0, 0, 16'h0,   0, 1, 16'h200, 16'h1234, 0, 1, 16'h200, 0, 0, 16'h0,    16'hBEEF);
        vecs[9]  = mk(0, 0, 16'h0,   0, 1, 16'h200, 16'h1234, 0, 0, 16'h0,   1, 0, 16'h0,    16'hBEEF);
        vecs[10] = mk(0, 0, 16'h0,   1, 0, 16'h200, 16'h0,    1, 0, 16'h200, 0, 0, 16'h0,    16'hBEEF);
        vecs[11] = mk(0, 0, 16'h0,   1, 0, 16'h200, 16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'hBEEF);
        vecs[12] = mk(0, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h1234);
        vecs[13] = mk(0, 0, 16'h0,   1, 1, 16'h204, 16'h7777, 0, 1, 16'h204, 0, 0, 16'h0,    16'h1234);
        vecs[14] = mk(0, 0, 16'h0,   1, 1, 16'h204, 16'h7777, 0, 0, 16'h0,   1, 0, 16'h0,    16'h1234);
        vecs[15] = mk(0, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h1234);
        vecs[16] = mk(0, 1, 16'h10,  1, 0, 16'h100, 16'h0,    1, 0, 16'h100, 0, 0, 16'h0,    16'h1234);
        vecs[17] = mk(0, 1, 16'h10,  1, 0, 16'h100, 16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h1234);
        for (int i = 18; i <= 22; i += 2) begin
            vecs[i]   = mk(0, 1, 16'h10, 1, 0, 16'h100, 16'h0, 1, 0, 16'h100, 0, 0, 16'h0, 16'hBEEF);
            vecs[i+1] = mk(0, 1, 16'h10, 1, 0, 16'h100, 16'h0, 0, 0, 16'h0,   1, 0, 16'h0, 16'hBEEF);
        end
        vecs[24] = mk(0, 1, 16'h10,  1, 0, 16'h100, 16'h0,    1, 0, 16'h10,  0, 0, 16'h0,    16'hBEEF);
        vecs[25] = mk(0, 1, 16'h10,  1, 0, 16'h100, 16'h0,    0, 0, 16'h0,   0, 1, 16'h5A03, 16'hBEEF);
        vecs[26] = mk(0, 1, 16'h10,  1, 0, 16'h100, 16'h0,    1, 0, 16'h100, 0, 0, 16'h0,    16'hBEEF);
        vecs[27] = mk(0, 1, 16'h10,  1, 0, 16'h100, 16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'hBEEF);
        vecs[28] = mk(0, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'hBEEF);
        vecs[29] = mk(0, 0, 16'h0,   1, 0, 16'h100, 16'h0,    1, 0, 16'h100, 0, 0, 16'h0,    16'hBEEF);
        vecs[30] = mk(1, 0, 16'h0,   1, 0, 16'h100, 16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);
        vecs[31] = mk(1, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);
        vecs[32] = mk(0, 1, 16'h10,  0, 0, 16'h0,   16'h0,    1, 0, 16'h10,  1, 0, 16'h0,    16'h0);
        vecs[33] = mk(0, 1, 16'h10,  0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 1, 16'h5A03, 16'h0);
        vecs[34] = mk(0, 0, 16'h0,   0, 0, 16'h0,   16'h0,    0, 0, 16'h0,   1, 0, 16'h0,    16'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            bus1.IReq      = vecs[i].ireq;
            bus1.IAddr     = vecs[i].iaddr;
            bus1.DReadReq  = vecs[i].drd;
            bus1.DWriteReq = vecs[i].dwr;
            bus1.DAddr     = vecs[i].daddr;
            bus1.DWData    = vecs[i].dwd;
            #1;
            chk($sformatf("v%0d MemRead", i),  16'(bus1.MemRead),  16'(vecs[i].mrd));
            chk($sformatf("v%0d MemWrite", i), 16'(bus1.MemWrite), 16'(vecs[i].mwr));
            chk($sformatf("v%0d DataDone", i), 16'(bus1.DataDone), 16'(vecs[i].done));
            chk($sformatf("v%0d IValid", i),   16'(bus1.IValid),   16'(vecs[i].ival));
            chk($sformatf("v%0d DRData", i),   bus1.DRData,        vecs[i].drdata);
            if (vecs[i].mrd || vecs[i].mwr)
                chk($sformatf("v%0d MemAddr", i), bus1.MemAddr, vecs[i].maddr);
            if (vecs[i].ival)
                chk($sformatf("v%0d IData", i), bus1.IData, vecs[i].idata);
            $display("vec %0d: rst=%b MemRead=%b MemWrite=%b MemAddr=%h DataDone=%b IValid=%b IData=%h DRData=%h",
                     i, rst, bus1.MemRead, bus1.MemWrite, bus1.MemAddr, bus1.DataDone,
                     bus1.IValid, bus1.IData, bus1.DRData);
        end

        // Latency 3: data read stalls for exactly three cycles.
        @(negedge clk);
        bus3.DReadReq = 1'b1;
        bus3.DAddr    = 16'h100;
        #1;
        chk("l3 read issue MemRead", 16'(bus3.MemRead), 16'd1);
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus3.DataDone) break;
            lows++;
            @(negedge clk);
            #1;
            if (!bus3.DataDone)
                chk("l3 read no re-drive", 16'(bus3.MemRead | bus3.MemWrite), 16'd0);
        end
        chk("l3 read low cycles", 16'(lows), 16'd3);
        bus3.DReadReq = 1'b0;
        @(negedge clk);
        #1;
        chk("l3 read DRData", bus3.DRData, 16'hBEEF);
        chk("l3 read DataDone after", 16'(bus3.DataDone), 16'd1);
        $display("l3 read: low cycles=%0d DRData=%h", lows, bus3.DRData);

        // Latency 3: fetch with IReq dropped while waiting still pulses IValid on cycle 3.
        @(negedge clk);
        bus3.IReq  = 1'b1;
        bus3.IAddr = 16'h10;
        #1;
        chk("l3 fetch MemRead", 16'(bus3.MemRead), 16'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus3.IReq = 1'b0;
            #1;
            chk($sformatf("l3 fetch c%0d IValid", c), 16'(bus3.IValid), (c == 3) ? 16'd1 : 16'd0);
            chk($sformatf("l3 fetch c%0d DataDone", c), 16'(bus3.DataDone), 16'd1);
            if (c == 3)
                chk("l3 fetch IData", bus3.IData, 16'h5A03);
            $display("l3 fetch cycle %0d: IValid=%b IData=%h", c, bus3.IValid, bus3.IData);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the processor's instruction-fetch port and its data port.
- Data accesses are normally favoured; a starvation counter guarantees instruction fetches progress.
- Drives the processor's DataDone stall input: the whole pipeline freezes while a data access is outstanding.
- Sits between the processor and the unified memory; purely sequential FSM plus counters.

Parameters:
WORD_SIZE, 16, data/instruction word width
ADDR_BITS, 16, memory address width
MEM_LATENCY, 1, cycles from a sampled MemRead/MemWrite to MemRData valid / write committed (legal 1..7)
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (legal 1..15)

Ports:
Clock  input  1  clock
Reset  input  1  reset
DReadReq  input  1  processor data read request (level, held while DataDone=0)
DWriteReq  input  1  processor data write request (level, held while DataDone=0)
DAddr  input  ADDR_BITS  data address
DWData  input  WORD_SIZE  store data
DRData  output  WORD_SIZE  load data to processor
DataDone  output  1  low = data access outstanding, processor stalls
IReq  input  1  fetch request (level)
IAddr  input  ADDR_BITS  fetch address
IData  output  WORD_SIZE  fetched instruction
IValid  output  1  one-cycle pulse, IData valid
MemAddr  output  ADDR_BITS  memory address
MemWData  output  WORD_SIZE  memory write data
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemRData  input  WORD_SIZE  memory read data

Behaviour:
- Reset: asynchronous, active-high; clock Clock. During and after reset:
  - state=IDLE, owner=none, lat_cnt=0, starve_cnt=0.
  - MemRead=MemWrite=0, MemAddr=MemWData=0.
  - IValid=0, IData=0, DRData=0.
  - DataDone=1.
  - Reset mid-access abandons the access; no IValid or DataDone completion is produced.
- States: IDLE, WAIT.
- IDLE issue (combinational within the cycle):
  - data_req = DReadReq|DWriteReq.
  - Grant D if data_req and not (IReq and starve_cnt==STARVE_LIMIT).
  - Else grant I if IReq.
  - D grant drives MemAddr=DAddr, MemRead=DReadReq, MemWrite=DWriteReq, MemWData=DWData.
  - I grant drives MemAddr=IAddr, MemRead=1.
  - On any grant: register owner and address/data, lat_cnt<=1, go to WAIT.
  - DReadReq and DWriteReq both high: write wins; a read is not issued.
- WAIT:
  - Strobes low; memory is not re-driven.
  - lat_cnt increments each cycle until lat_cnt==MEM_LATENCY, which is the completion cycle; then go to IDLE.
  - D owner completion: DRData<=MemRData (reads only, registered, visible the cycle after completion and held until the next data read completes); DataDone=1 that cycle.
  - I owner completion: IData=MemRData and IValid=1 for exactly that cycle.
- DataDone (combinational) = 0 when any of:
  - IDLE with data_req;
  - WAIT with D owner and not yet complete;
  - WAIT with I owner and data_req.
  - Otherwise 1.
  - A request still asserted in the IDLE cycle after a completion is a new access.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each D grant made while IReq=1.
  - Clears on an I grant, or on a D grant with IReq=0.
- Throughput: one access per MEM_LATENCY+1 cycles; no back-to-back issue from WAIT.
- IReq dropping while an I access is in WAIT: the access still completes and IValid still pulses.

Test Plan:
1. Reset, IReq=1, IAddr=0x0010, mem[0x0010]=0x5A03, MEM_LATENCY=1 -> MemRead=1/MemAddr=0x0010 in cycle 0, IValid=1 with IData=0x5A03 in cycle 1, DataDone=1 throughout.
2. DReadReq=1, DAddr=0x0100, mem=0xBEEF, IReq=0 -> DataDone=0 cycle 0, DataDone=1 cycle 1, DRData=0xBEEF from cycle 2.
3. DWriteReq=1, DAddr=0x0200, DWData=0x1234, then a read of 0x0200 -> MemWrite=1 for one cycle, read returns 0x1234.
4. IReq=1 and DReadReq=1 held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,... with DataDone=0 during the I access.
5. MEM_LATENCY=3, data read -> DataDone low for exactly 3 cycles, high on cycle 3.
6. Reset asserted during WAIT of a data read -> no IValid, DataDone=1, state IDLE. After release, a fresh request completes normally.
